// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer and the ALU itself.
//   OPW          opcode width
//   OP_*         supported 6-bit opcodes
//   state_e      sequencer state encoding (also driven out on STATE)
//   op_supported 1 when the opcode is one the ALU implements
package alu_pkg;

  localparam int OPW = 6;

  localparam logic [OPW-1:0] OP_ADD = 6'b100000;
  localparam logic [OPW-1:0] OP_SUB = 6'b100010;
  localparam logic [OPW-1:0] OP_AND = 6'b100100;
  localparam logic [OPW-1:0] OP_OR  = 6'b100101;
  localparam logic [OPW-1:0] OP_XOR = 6'b100110;
  localparam logic [OPW-1:0] OP_NOR = 6'b100111;
  localparam logic [OPW-1:0] OP_SRA = 6'b000011;
  localparam logic [OPW-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4
  } state_e;

  function automatic logic op_supported(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_supported = 1'b1;
      default:                        op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Turns a raw, bouncing, asynchronous button into a single-cycle press pulse.
//   CLK     clock
//   RST_N   synchronous active-low reset
//   BTN     raw button level (asynchronous)
//   press   1-cycle pulse per accepted 0->1 transition of the debounced level
module btn_conditioner #(
  parameter int DEB_CYC = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic press
);

  // Counter only needs to reach DEB_CYC-1.
  localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);

  logic [1:0]    r_sync;
  logic          r_lvl;   // debounced level
  logic [CW-1:0] r_cnt;   // consecutive cycles the synced level differs from r_lvl
  logic          r_press;

  logic w_diff;
  logic w_done;

  assign w_diff = r_sync[1] ^ r_lvl;
  assign w_done = w_diff && (r_cnt == CW'(DEB_CYC - 1));
  assign press  = r_press;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_sync  <= '0;
      r_lvl   <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], BTN};
      // Any return to the current debounced level restarts the count, so a
      // glitch shorter than DEB_CYC cycles never flips r_lvl.
      if (w_done) begin
        r_lvl <= r_sync[1];
        r_cnt <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      // Only the debounced rising edge is a press; holding gives one pulse.
      r_press <= w_done & r_sync[1];
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Operator sequencer for the 8-bit ALU: loads A, B and OP from a shared
// switch bus on successive button presses, then latches the ALU result.
//   CLK, RST_N   clock, synchronous active-low reset
//   SW           shared operand/opcode switches
//   BTN          raw load/advance button
//   ALU_A/B/OP   registered operands/opcode to the external ALU
//   ALU_Z        combinational ALU result
//   RESULT       registered result, RES_VALID while it is current
//   ERR          last opcode entered was unsupported
//   STATE        current state code
module alu_seq_ctrl #(
  parameter int DW      = 8,
  parameter int OPW     = 6,
  parameter int DEB_CYC = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [DW-1:0]  SW,
  input  logic           BTN,
  output logic [DW-1:0]  ALU_A,
  output logic [DW-1:0]  ALU_B,
  output logic [OPW-1:0] ALU_OP,
  input  logic [DW-1:0]  ALU_Z,
  output logic [DW-1:0]  RESULT,
  output logic           RES_VALID,
  output logic           ERR,
  output logic [2:0]     STATE
);

  import alu_pkg::*;

  state_e         r_state;
  logic [DW-1:0]  r_alu_a;
  logic [DW-1:0]  r_alu_b;
  logic [OPW-1:0] r_alu_op;
  logic [DW-1:0]  r_result;
  logic           r_res_valid;
  logic           r_err;

  logic           w_press;

  btn_conditioner #(.DEB_CYC(DEB_CYC)) u_btn (
    .CLK   (CLK),
    .RST_N (RST_N),
    .BTN   (BTN),
    .press (w_press)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= ST_WAIT_A;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_result    <= '0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_A: if (w_press) begin
          r_alu_a <= SW;
          r_state <= ST_WAIT_B;
        end
        ST_WAIT_B: if (w_press) begin
          r_alu_b <= SW;
          r_state <= ST_WAIT_OP;
        end
        ST_WAIT_OP: if (w_press) begin
          // Bad opcode keeps the previous ALU_OP and waits for another try.
          if (op_supported(SW[OPW-1:0])) begin
            r_alu_op <= SW[OPW-1:0];
            r_err    <= 1'b0;
            r_state  <= ST_EXEC;
          end else begin
            r_err    <= 1'b1;
          end
        end
        // One cycle for the ALU to settle on the new opcode; a press landing
        // here is dropped.
        ST_EXEC: begin
          r_result    <= ALU_Z;
          r_res_valid <= 1'b1;
          r_state     <= ST_SHOW;
        end
        ST_SHOW: if (w_press) begin
          r_res_valid <= 1'b0;
          r_state     <= ST_WAIT_A;
        end
        default: r_state <= ST_WAIT_A;
      endcase
    end
  end

  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_OP    = r_alu_op;
  assign RESULT    = r_result;
  assign RES_VALID = r_res_valid;
  assign ERR       = r_err;
  assign STATE     = r_state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  localparam int DW   = 8;
  localparam int HOLD = 12;  // enough for sync + DEB_CYC + press register
  localparam int REL  = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] sw;
  logic          btn;
  logic [DW-1:0] alu_a, alu_b, alu_z, result;
  logic [5:0]    alu_op;
  logic          res_valid, err;
  logic [2:0]    state;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DW(DW), .OPW(6), .DEB_CYC(4)) dut (
    .CLK(clk), .RST_N(rst_n), .SW(sw), .BTN(btn),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OP(alu_op), .ALU_Z(alu_z),
    .RESULT(result), .RES_VALID(res_valid), .ERR(err), .STATE(state)
  );

  // Reference ALU sitting outside the sequencer.
  always_comb begin
    alu_z = '0;
    case (alu_op)
      OP_ADD: alu_z = alu_a + alu_b;
      OP_SUB: alu_z = alu_a - alu_b;
      OP_AND: alu_z = alu_a & alu_b;
      OP_OR:  alu_z = alu_a | alu_b;
      OP_XOR: alu_z = alu_a ^ alu_b;
      OP_NOR: alu_z = ~(alu_a | alu_b);
      OP_SRA: alu_z = $signed(alu_a) >>> alu_b[2:0];
      OP_SRL: alu_z = alu_a >> alu_b[2:0];
      default: alu_z = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Clean press with SW held; reports the first state the FSM moves to.
  task automatic press(input logic [7:0] v, output logic [2:0] nxt);
    logic [2:0] prior;
    logic       seen;
    prior = state;
    nxt   = state;
    seen  = 1'b0;
    sw    = v;
    btn   = 1'b1;
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      if (!seen && state != prior) begin
        seen = 1'b1;
        nxt  = state;
      end
    end
    btn = 1'b0;
    repeat (REL) @(negedge clk);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op, input logic [7:0] exp);
    logic [2:0] nxt;
    press(a, nxt);
    press(b, nxt);
    press(op, nxt);
    chk({tag, "_exec"}, nxt, 3);
    chk({tag, "_state"}, state, 4);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_vld"}, res_valid, 1);
    press(8'h00, nxt);
    chk({tag, "_back"}, state, 0);
    chk({tag, "_vld0"}, res_valid, 0);
    chk({tag, "_hold"}, result, exp);
  endtask

  initial begin
    logic [2:0] nxt;
    logic       found;
    rst_n = 1'b0;
    sw    = '0;
    btn   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_res", result, 0);
    chk("rst_vld", res_valid, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_op("sra_basic", 8'h0B, 8'h01, 8'h03, 8'h05);
    run_op("sra_sign",  8'h8B, 8'h01, 8'h03, 8'hC5);
    run_op("sra_fill",  8'h80, 8'h07, 8'h03, 8'hFF);
    run_op("add_wrap",  8'h7F, 8'h01, 8'h20, 8'h80);
    run_op("add_zero",  8'hFF, 8'h01, 8'h20, 8'h00);
    run_op("sub_wrap",  8'h05, 8'h07, 8'h22, 8'hFE);
    run_op("srl",       8'h80, 8'h07, 8'h02, 8'h01);
    run_op("nor",       8'h0F, 8'h30, 8'h27, 8'hC0);

    // Bounce: pulses shorter than the debounce window never advance.
    btn = 1'b1; repeat (2) @(negedge clk);
    btn = 1'b0; repeat (1) @(negedge clk);
    btn = 1'b1; repeat (3) @(negedge clk);
    btn = 1'b0; repeat (REL) @(negedge clk);
    chk("bounce_state", state, 0);

    // Long hold: exactly one advance.
    sw  = 8'h10;
    btn = 1'b1; repeat (50) @(negedge clk);
    btn = 1'b0; repeat (REL) @(negedge clk);
    chk("hold_state", state, 1);
    chk("hold_a", alu_a, 8'h10);

    // Illegal opcode then a good one.
    press(8'h02, nxt);
    press(8'h3F, nxt);
    chk("ill_state", state, 2);
    chk("ill_err", err, 1);
    chk("ill_vld", res_valid, 0);
    press(8'h03, nxt);
    chk("ok_exec", nxt, 3);
    chk("ok_err", err, 0);
    chk("ok_res", result, 8'h04);
    press(8'h00, nxt);
    chk("ok_back", state, 0);

    // Reset asserted on the very edge a press is presented in WAIT_OP.
    press(8'h5A, nxt);
    press(8'hA5, nxt);
    chk("mid_wait_op", state, 2);
    sw    = 8'h03;
    btn   = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dut.u_btn.press) found = 1'b1;
    end
    chk("mid_press_seen", found, 1);
    rst_n = 1'b0;
    btn   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_state", state, 0);
    chk("mid_a", alu_a, 0);
    chk("mid_b", alu_b, 0);
    chk("mid_op", alu_op, 0);
    chk("mid_res", result, 0);
    chk("mid_vld", res_valid, 0);
    chk("mid_err", err, 0);
    repeat (REL) @(negedge clk);
    chk("mid_quiet", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
